// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter: datapath widths, opcode
// constants, slot state encoding and the undefined-opcode decode.
package alu_share_arbiter_pkg;

  localparam int DATA_W   = 32;
  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'h9;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'hA;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'hB;
  localparam logic [ALU_OP_W-1:0] ALU_GTZ  = 4'hC;

  // The result slot is either holding an unconsumed result or free.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Opcodes with no ALU function; the ALU returns 0 for them and the
  // arbiter flags them back to the requester.
  function automatic logic op_is_undef(input logic [ALU_OP_W-1:0] op);
    logic undef;
    case (op)
      4'h2, 4'hD, 4'hE, 4'hF: undef = 1'b1;
      default:                undef = 1'b0;
    endcase
    return undef;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by several pipeline requesters.
// Shifts take the amount from In1[4:0] and shift In2.
module alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [ALU_OP_W-1:0] ALUOp,
  input  logic [DATA_W-1:0]   In1,
  input  logic [DATA_W-1:0]   In2,
  output logic [DATA_W-1:0]   Result,
  output logic                Zero
);

  logic [4:0] shamt;
  assign shamt = In1[4:0];

  // Opcode decode; undefined opcodes yield zero.
  always_comb begin
    Result = '0;
    case (ALUOp)
      ALU_ADD:  Result = In1 + In2;
      ALU_SUB:  Result = In1 - In2;
      ALU_AND:  Result = In1 & In2;
      ALU_OR:   Result = In1 | In2;
      ALU_XOR:  Result = In1 ^ In2;
      ALU_NOR:  Result = ~(In1 | In2);
      ALU_SLTU: Result = {{(DATA_W-1){1'b0}}, (In1 < In2)};
      ALU_SLT:  Result = {{(DATA_W-1){1'b0}}, ($signed(In1) < $signed(In2))};
      ALU_SLL:  Result = In2 << shamt;
      ALU_SRL:  Result = In2 >> shamt;
      ALU_SRA:  Result = $unsigned($signed(In2) >>> shamt);
      ALU_GTZ:  Result = {{(DATA_W-1){1'b0}}, ($signed(In1) > 0)};
      default:  Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above ptr,
// wrapping modulo NUM_REQ. Produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NUM_REQ) ? (s - NUM_REQ) : s;
  endfunction

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(int'(ptr), k)]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(wrap_idx(int'(ptr), k));
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = grant_any && (grant_idx == PTR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ requesters. Round-robin grant, valid/ready
// handshake per requester, and a single registered result slot that can be
// consumed and reloaded in the same cycle (1 op/cycle, 1 cycle latency).
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [ALU_OP_W*NUM_REQ-1:0] req_op,
  input  logic [DATA_W*NUM_REQ-1:0]   req_in1,
  input  logic [DATA_W*NUM_REQ-1:0]   req_in2,
  input  logic [TAG_W*NUM_REQ-1:0]    req_tag,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic [DATA_W-1:0]           resp_result,
  output logic                        resp_zero,
  output logic                        resp_err,
  output logic [TAG_W-1:0]            resp_tag
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Per-requester views of the flattened request buses.
  logic [ALU_OP_W-1:0] op_arr  [NUM_REQ];
  logic [DATA_W-1:0]   in1_arr [NUM_REQ];
  logic [DATA_W-1:0]   in2_arr [NUM_REQ];
  logic [TAG_W-1:0]    tag_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi]  = req_op[ALU_OP_W*gi +: ALU_OP_W];
      assign in1_arr[gi] = req_in1[DATA_W*gi +: DATA_W];
      assign in2_arr[gi] = req_in2[DATA_W*gi +: DATA_W];
      assign tag_arr[gi] = req_tag[TAG_W*gi +: TAG_W];
    end
  endgenerate

  slot_state_e         slot_state_reg, slot_state_next;
  logic [PTR_W-1:0]    owner_reg, owner_next;
  logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [DATA_W-1:0]   result_reg, result_next;
  logic                zero_reg, zero_next;
  logic                err_reg, err_next;
  logic [TAG_W-1:0]    tag_reg, tag_next;

  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_any;
  logic                slot_full;
  logic                owner_ready;
  logic                can_accept;
  logic                accept;

  logic [ALU_OP_W-1:0] alu_op;
  logic [DATA_W-1:0]   alu_in1;
  logic [DATA_W-1:0]   alu_in2;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The slot can take a new result when free, or when its owner is
  // draining it this very cycle; resp_ready from other requesters is ignored.
  assign slot_full   = (slot_state_reg == SLOT_FULL);
  assign owner_ready = resp_ready[owner_reg];
  assign can_accept  = !slot_full || owner_ready;
  assign accept      = grant_any && can_accept;
  assign req_ready   = can_accept ? grant : '0;

  // Granted requester's operands feed the shared ALU.
  assign alu_op  = op_arr[grant_idx];
  assign alu_in1 = in1_arr[grant_idx];
  assign alu_in2 = in2_arr[grant_idx];

  alu u_alu (
    .ALUOp  (alu_op),
    .In1    (alu_in1),
    .In2    (alu_in2),
    .Result (alu_result),
    .Zero   (alu_zero)
  );

  // Slot load/drain and round-robin pointer advance.
  always_comb begin
    slot_state_next = slot_state_reg;
    owner_next      = owner_reg;
    rr_ptr_next     = rr_ptr_reg;
    result_next     = result_reg;
    zero_next       = zero_reg;
    err_next        = err_reg;
    tag_next        = tag_reg;
    if (accept) begin
      slot_state_next = SLOT_FULL;
      owner_next      = grant_idx;
      result_next     = alu_result;
      zero_next       = alu_zero;
      err_next        = op_is_undef(alu_op);
      tag_next        = tag_arr[grant_idx];
      rr_ptr_next     = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (slot_full && owner_ready) begin
      slot_state_next = SLOT_EMPTY;
    end
  end

  // State registers; reset discards any held or in-flight result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_state_reg <= SLOT_EMPTY;
      owner_reg      <= '0;
      rr_ptr_reg     <= '0;
      result_reg     <= '0;
      zero_reg       <= 1'b0;
      err_reg        <= 1'b0;
      tag_reg        <= '0;
    end else begin
      slot_state_reg <= slot_state_next;
      owner_reg      <= owner_next;
      rr_ptr_reg     <= rr_ptr_next;
      result_reg     <= result_next;
      zero_reg       <= zero_next;
      err_reg        <= err_next;
      tag_reg        <= tag_next;
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_resp_valid
      assign resp_valid[gi] = slot_full && (owner_reg == PTR_W'(gi));
    end
  endgenerate

  assign resp_result = result_reg;
  assign resp_zero   = zero_reg;
  assign resp_err    = err_reg;
  assign resp_tag    = tag_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two requesters.
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 4;

  logic                    clk;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [4*NUM_REQ-1:0]    req_op;
  logic [32*NUM_REQ-1:0]   req_in1;
  logic [32*NUM_REQ-1:0]   req_in2;
  logic [TAG_W*NUM_REQ-1:0] req_tag;
  logic [NUM_REQ-1:0]      resp_valid;
  logic [NUM_REQ-1:0]      resp_ready;
  logic [31:0]             resp_result;
  logic                    resp_zero;
  logic                    resp_err;
  logic [TAG_W-1:0]        resp_tag;

  int checks;
  int failures;

  alu_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_in1     (req_in1),
    .req_in2     (req_in2),
    .req_tag     (req_tag),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err),
    .resp_tag    (resp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] in1,
                         input logic [31:0] in2, input logic [3:0] tag);
    req_op[4*i +: 4]   = op;
    req_in1[32*i +: 32] = in1;
    req_in2[32*i +: 32] = in2;
    req_tag[4*i +: 4]  = tag;
  endtask

  task automatic check_resp(input string name, input logic [1:0] valid, input logic [31:0] result,
                            input logic zero, input logic err, input logic [3:0] tag);
    $display("txn %s: resp_valid=%b result=0x%08h zero=%b err=%b tag=%0d",
             name, resp_valid, resp_result, resp_zero, resp_err, resp_tag);
    check({name, ".valid"},  32'(resp_valid), 32'(valid));
    check({name, ".result"}, resp_result, result);
    check({name, ".zero"},   32'(resp_zero), 32'(zero));
    check({name, ".err"},    32'(resp_err), 32'(err));
    check({name, ".tag"},    32'(resp_tag), 32'(tag));
  endtask

  // Single requester issues one op; caller has set resp_ready.
  task automatic do_op(input string name, input int who, input logic [3:0] op,
                       input logic [31:0] in1, input logic [31:0] in2, input logic [3:0] tag,
                       input logic [31:0] exp_result, input logic exp_zero, input logic exp_err);
    logic [1:0] who_mask;
    who_mask  = (who == 1) ? 2'b10 : 2'b01;
    req_valid = who_mask;
    set_req(who, op, in1, in2, tag);
    #1;
    check({name, ".req_ready"}, 32'(req_ready), 32'(who_mask));
    tick();
    check_resp(name, who_mask, exp_result, exp_zero, exp_err, tag);
  endtask

  initial begin
    logic [1:0] exp_grant;
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    req_valid  = '0;
    req_op     = '0;
    req_in1    = '0;
    req_in2    = '0;
    req_tag    = '0;
    resp_ready = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_resp("reset", 2'b00, 32'h0, 1'b0, 1'b0, 4'h0);
    check("reset.req_ready", 32'(req_ready), 32'h0);
    #2 reset = 1'b1;
    #1;

    // 1: requester 0 alone, add 5+7
    do_op("t1_add", 0, 4'h0, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 1'b0);
    // owner drains, slot goes empty; rr_ptr now 1
    req_valid  = '0;
    resp_ready = 2'b01;
    tick();
    check("t1_drain.valid", 32'(resp_valid), 32'h0);

    // 2: both requesting every cycle, sub 3-3, grants alternate from ptr=1
    resp_ready = 2'b11;
    req_valid  = 2'b11;
    set_req(0, 4'h1, 32'd3, 32'd3, 4'd1);
    set_req(1, 4'h1, 32'd3, 32'd3, 4'd2);
    exp_grant = 2'b10;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t2.req_ready", 32'(req_ready), 32'(exp_grant));
      tick();
      check_resp("t2_sub", exp_grant, 32'h0, 1'b1, 1'b0, (exp_grant == 2'b10) ? 4'd2 : 4'd1);
      exp_grant = ~exp_grant;
    end

    // 3: slot full (owner 0), not consumed for 3 cycles; non-owner ready ignored
    set_req(0, 4'h0, 32'd10, 32'd20, 4'd5);
    set_req(1, 4'h0, 32'd1, 32'd2, 4'd6);
    for (int c = 0; c < 3; c++) begin
      resp_ready = (c == 1) ? 2'b10 : 2'b00;
      #1;
      check("t3_stall.req_ready", 32'(req_ready), 32'h0);
      tick();
      check_resp("t3_stall", 2'b01, 32'h0, 1'b1, 1'b0, 4'd1);
    end
    resp_ready = 2'b01;
    #1;
    check("t3_release.req_ready", 32'(req_ready), 32'h2);
    tick();
    check_resp("t3_r1", 2'b10, 32'd3, 1'b0, 1'b0, 4'd6);
    resp_ready = 2'b10;
    do_op("t3_r0", 0, 4'h0, 32'd10, 32'd20, 4'd5, 32'd30, 1'b0, 1'b0);

    // 4: undefined opcode, then err clears
    resp_ready = 2'b01;
    do_op("t4_undef", 0, 4'hF, 32'd1, 32'd1, 4'd7, 32'h0, 1'b1, 1'b1);
    do_op("t4_add",   0, 4'h0, 32'd2, 32'd3, 4'd8, 32'd5, 1'b0, 1'b0);

    // 5: shifts, compares, logic on requester 1
    resp_ready = 2'b11;
    do_op("t5_sra",  1, 4'hB, 32'd1, 32'hFFFF_FFF8, 4'd9,  32'hFFFF_FFFC, 1'b0, 1'b0);
    do_op("t5_gtz",  1, 4'hC, 32'h8000_0000, 32'd0, 4'd10, 32'h0, 1'b1, 1'b0);
    do_op("t5_slt",  1, 4'h8, 32'hFFFF_FFFF, 32'd1, 4'd11, 32'd1, 1'b0, 1'b0);
    do_op("t5_sltu", 1, 4'h7, 32'hFFFF_FFFF, 32'd1, 4'd12, 32'd0, 1'b1, 1'b0);
    do_op("t5_nor",  1, 4'h6, 32'h0, 32'h0, 4'd13, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("t5_sll",  1, 4'h9, 32'd4, 32'd1, 4'd14, 32'd16, 1'b0, 1'b0);
    do_op("t5_srl",  1, 4'hA, 32'd4, 32'h100, 4'd15, 32'h10, 1'b0, 1'b0);
    do_op("t5_gtz1", 1, 4'hC, 32'd1, 32'd0, 4'd2, 32'd1, 1'b0, 1'b0);

    // 6: async reset while resp_valid=10 with both requesting
    req_valid = 2'b11;
    set_req(0, 4'h4, 32'hF0, 32'h0F, 4'd4);
    set_req(1, 4'h5, 32'hFF, 32'h0F, 4'd6);
    #1 reset = 1'b0;
    #1;
    check_resp("t6_reset", 2'b00, 32'h0, 1'b0, 1'b0, 4'h0);
    check("t6_reset.req_ready", 32'(req_ready), 32'h1);
    tick();
    check_resp("t6_hold", 2'b00, 32'h0, 1'b0, 1'b0, 4'h0);
    #2 reset = 1'b1;
    #1;
    check("t6_release.req_ready", 32'(req_ready), 32'h1);
    tick();
    check_resp("t6_or", 2'b01, 32'hFF, 1'b0, 1'b0, 4'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
